// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch front end: branch kinds, ARM condition codes,
// fetch FSM states and sticky error-bit positions.
package fetch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_COND = 3'd2,
    BR_CBZ  = 3'd3,
    BR_CBNZ = 3'd4,
    BR_REG  = 3'd5
  } br_kind_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int ERR_ALIGN   = 0;
  localparam int ERR_RANGE   = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_KIND    = 3;

endpackage

// File: rtl/fetch_unit_cond_eval.sv
// ARM condition-code evaluation against {N,Z,C,V}; purely combinational so the
// execute stage's conditional-select logic can share it.
module cond_eval
  import fetch_pkg::*;
(
  input  logic [3:0] br_cond,
  input  logic [3:0] pstate,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = pstate[3];
  assign w_z = pstate[2];
  assign w_c = pstate[1];
  assign w_v = pstate[0];

  always_comb begin
    pass = 1'b1;
    case (br_cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !(w_c && !w_z);
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = !(!w_z && (w_n == w_v));
      default: pass = 1'b1;  // AL and NV
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and branch resolution front end with variable-latency IMEM.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              IMEM_AW  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic                imem_req,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_valid,
  output logic [31:0]         instr_out,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic [2:0]          br_kind,
  input  logic [3:0]          br_cond,
  input  logic [ADDR_W-3:0]   br_offset,
  input  logic [ADDR_W-1:0]   br_reg_val,
  input  logic [3:0]          pstate,
  output logic                halted,
  output logic [3:0]          err_bits
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int PW = ADDR_W - 2;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            r_state;
  logic [PW-1:0]     r_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic              r_halted;
  logic [3:0]        r_err;
  logic [CW-1:0]     r_cnt;

  logic [ADDR_W-1:0] w_pc_byte;
  logic [ADDR_W-1:0] w_rel;
  logic [ADDR_W-1:0] w_target;
  logic              w_taken;
  logic              w_cond_pass;
  logic [3:0]        w_err_new;

  cond_eval u_cond_eval (
    .br_cond (br_cond),
    .pstate  (pstate),
    .pass    (w_cond_pass)
  );

  assign w_pc_byte = {r_pc, 2'b00};
  assign w_rel     = w_pc_byte + {br_offset, 2'b00};

  always_comb begin
    w_taken   = 1'b0;
    w_target  = w_rel;
    w_err_new = '0;
    case (br_kind_e'(br_kind))
      BR_NONE: w_taken = 1'b0;
      BR_B:    w_taken = 1'b1;
      BR_COND: w_taken = w_cond_pass;
      BR_CBZ:  w_taken = (br_reg_val == '0);
      BR_CBNZ: w_taken = (br_reg_val != '0);
      BR_REG: begin
        w_taken  = 1'b1;
        w_target = br_reg_val;
      end
      default: w_err_new[ERR_KIND] = 1'b1;
    endcase
    // Target checks only matter when the branch actually redirects the PC.
    w_err_new[ERR_ALIGN] = w_taken && (w_target[1:0] != 2'b00);
    w_err_new[ERR_RANGE] = w_taken && ((w_target >> IMEM_AW) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC[ADDR_W-1:2];
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_err         <= '0;
      r_cnt         <= '0;
    end else if (clk_en) begin
      case (r_state)
        FETCH: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(TIMEOUT - 1)) begin
              r_err[ERR_TIMEOUT] <= 1'b1;
              r_halted           <= 1'b1;
              r_state            <= HALT;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            r_instr_valid <= 1'b0;
            if (w_err_new != '0) begin
              r_err    <= r_err | w_err_new;
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else begin
              r_pc    <= w_taken ? w_target[ADDR_W-1:2] : r_pc + PW'(1);
              r_state <= FETCH;
            end
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

  // Request is gated by rst so it is low in the reset cycle itself.
  assign imem_req    = ((r_state == FETCH) || (r_state == WAIT)) && !rst;
  assign imem_addr   = {r_pc[IMEM_AW-3:0], 2'b00};
  assign instr_out   = r_instr;
  assign instr_pc    = w_pc_byte;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign err_bits    = r_err;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else if (clk_en) begin
      if ((r_state == HOLD) && instr_ready)
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (((r_state == WAIT) && !imem_valid) || ((r_state == HOLD) && !instr_ready))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
